// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-based press/release debounce.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned REPEAT_DELAY    = 32,
  parameter int unsigned REPEAT_RATE     = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_is_digit,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEB_N     = CNT_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_e;

  function automatic logic [1:0] row_index(input logic [3:0] rn);
    case (rn)
      4'b1110: row_index = 2'd0;
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      default: row_index = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;
      4'h1: key_map = 4'h2;
      4'h2: key_map = 4'h3;
      4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;
      4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h6;
      4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;
      4'h9: key_map = 4'h8;
      4'hA: key_map = 4'h9;
      4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;
      4'hD: key_map = 4'h0;
      4'hE: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  logic [3:0]        col_s1_q, col_s2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [3:0]        row_n_q, row_n_d;
  logic [1:0]        fr_cnt_q, fr_cnt_d;
  logic [3:0]        fr_code_q, fr_code_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_is_digit_q, key_is_digit_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic [3:0] closed;
  logic [2:0] row_ones;
  logic [1:0] row_hits;
  logic [1:0] col_idx;
  logic [2:0] tot;
  logic       sample, frame_end, frame_single;
  logic [3:0] frame_key;
  logic [CNT_W-1:0] cnt_inc;
  logic       accept;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] REP_DLY  = 8'(REPEAT_DELAY);
  localparam logic [7:0] REP_RATE = 8'(REPEAT_RATE);
  logic [7:0] held_q, held_d;
  logic [7:0] rate_q, rate_d;
  logic [7:0] held_sat;
`endif

  // Row scan and per-frame contact accumulation
  always_comb begin
    slot_d    = slot_q;
    row_n_d   = row_n_q;
    fr_cnt_d  = fr_cnt_q;
    fr_code_d = fr_code_q;
    closed    = ~col_s2_q;
    row_ones  = 3'($countones(closed));
    row_hits  = (row_ones > 3'd1) ? 2'd2 : row_ones[1:0];
    col_idx   = 2'd3;
    if (closed[0])      col_idx = 2'd0;
    else if (closed[1]) col_idx = 2'd1;
    else if (closed[2]) col_idx = 2'd2;
    sample       = (slot_q == SLOT_LAST);
    frame_end    = sample && !row_n_q[3];
    tot          = {1'b0, fr_cnt_q} + {1'b0, row_hits};
    frame_single = frame_end && (tot == 3'd1);
    frame_key    = (row_hits == 2'd1) ? key_map(row_index(row_n_q), col_idx) : fr_code_q;
    if (sample) begin
      slot_d  = '0;
      row_n_d = {row_n_q[2:0], row_n_q[3]};
      if (frame_end) begin
        fr_cnt_d  = 2'd0;
        fr_code_d = 4'd0;
      end else begin
        fr_cnt_d  = (tot > 3'd1) ? 2'd2 : tot[1:0];
        fr_code_d = frame_key;
      end
    end else begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  // Debounce FSM, evaluated only at frame end
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cand_d         = cand_q;
    key_code_d     = key_code_q;
    key_is_digit_d = key_is_digit_q;
    key_valid_d    = 1'b0;
    accept         = 1'b0;
    cnt_inc        = cnt_q + CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
    held_d   = held_q;
    rate_d   = rate_q;
    held_sat = (held_q == 8'hFF) ? held_q : held_q + 8'd1;
`endif
    if (frame_end) begin
      case (state_q)
        S_IDLE: begin
          if (frame_single) begin
            cand_d = frame_key;
            cnt_d  = CNT_W'(1);
            if (DEB_N == CNT_W'(1)) begin
              accept  = 1'b1;
              state_d = S_PRESSED;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (!frame_single) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (frame_key == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              accept  = 1'b1;
              state_d = S_PRESSED;
            end
          end else begin
            cand_d = frame_key;
            cnt_d  = CNT_W'(1);
          end
        end
        S_PRESSED: begin
          if (!frame_single) begin
            if (DEB_N == CNT_W'(1)) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            held_d = held_sat;
            if (held_sat == REP_DLY && held_sat != held_q) begin
              key_valid_d = 1'b1;
              rate_d      = 8'd0;
            end else if (held_sat > REP_DLY) begin
              if (rate_q + 8'd1 == REP_RATE) begin
                key_valid_d = 1'b1;
                rate_d      = 8'd0;
              end else begin
                rate_d = rate_q + 8'd1;
              end
            end
`endif
          end
        end
        default: begin
          if (frame_single) begin
            state_d = S_PRESSED;
          end else if (cnt_inc == DEB_N) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
    if (accept) begin
      key_code_d     = cand_d;
      key_is_digit_d = (cand_d <= 4'd9);
      key_valid_d    = 1'b1;
    end
    key_held_d = (state_d == S_PRESSED) || (state_d == S_RELEASE);
`ifdef KEYPAD_REPEAT_EN
    // Hold count survives release bounces; clears only once the key is gone
    if (!key_held_d) begin
      held_d = 8'd0;
      rate_d = 8'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q       <= 4'hF;
      col_s2_q       <= 4'hF;
      slot_q         <= '0;
      row_n_q        <= 4'b1110;
      fr_cnt_q       <= 2'd0;
      fr_code_q      <= 4'd0;
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      cand_q         <= 4'd0;
      key_code_q     <= 4'd0;
      key_is_digit_q <= 1'b0;
      key_valid_q    <= 1'b0;
      key_held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      held_q         <= 8'd0;
      rate_q         <= 8'd0;
`endif
    end else begin
      col_s1_q       <= col_n;
      col_s2_q       <= col_s1_q;
      slot_q         <= slot_d;
      row_n_q        <= row_n_d;
      fr_cnt_q       <= fr_cnt_d;
      fr_code_q      <= fr_code_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cand_q         <= cand_d;
      key_code_q     <= key_code_d;
      key_is_digit_q <= key_is_digit_d;
      key_valid_q    <= key_valid_d;
      key_held_q     <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      held_q         <= held_d;
      rate_q         <= rate_d;
`endif
    end
  end

  assign row_n        = row_n_q;
  assign key_code     = key_code_q;
  assign key_is_digit = key_is_digit_q;
  assign key_valid    = key_valid_q;
  assign key_held     = key_held_q;

endmodule
